// File: rtl/timer_multi.sv
// Purpose: NCH independent prescaled up-counters with period compare, one-shot mode, irq and toggle outputs.
// Latency: reads are combinational (zero cycles); writes land at the next edge; irq lags TMR/IE by one cycle.
// Backpressure: none; every wren/rden cycle is accepted, and a read of CONTROL clears TMR at that edge.
module timer_multi #(
  parameter int          WIDTH     = 32,
  parameter int          NCH       = 4,
  parameter int          PSC_WIDTH = 8,
  parameter logic [31:0] PERIOD    = 32'h0000000F,
  parameter logic        ENBIT     = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  input  logic                      wren,
  input  logic                      rden,
  input  logic [$clog2(NCH)+1:0]    addr,
  output logic                      irq,
  output logic [NCH-1:0]            tog
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = $clog2(NCH) + 2;
  localparam logic [WIDTH-1:0] PERIOD_RST = PERIOD[WIDTH-1:0];

  localparam logic [1:0] REG_TIMER  = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_PSC    = 2'd3;

  // Per-channel state
  logic [WIDTH-1:0]     timer_q   [NCH];
  logic [WIDTH-1:0]     timer_d   [NCH];
  logic [WIDTH-1:0]     period_q  [NCH];
  logic [WIDTH-1:0]     period_d  [NCH];
  logic [PSC_WIDTH-1:0] psc_q     [NCH];
  logic [PSC_WIDTH-1:0] psc_d     [NCH];
  logic [PSC_WIDTH-1:0] psc_cnt_q [NCH];
  logic [PSC_WIDTH-1:0] psc_cnt_d [NCH];
  logic [NCH-1:0]       en_q, en_d;
  logic [NCH-1:0]       tmr_q, tmr_d;
  logic [NCH-1:0]       tog_q, tog_d;
  logic [NCH-1:0]       os_q, os_d;
  logic [NCH-1:0]       ie_q, ie_d;
  logic                 irq_q;

  logic [CW-1:0]        ch_sel;
  logic [1:0]           reg_sel;
  logic [NCH-1:0]       hit;
  logic [NCH-1:0]       tick;
  logic [WIDTH-1:0]     rdata;

  assign reg_sel = addr[1:0];

  generate
    if (NCH > 1) begin : g_multi
      assign ch_sel = addr[AW-1:2];
    end else begin : g_single
      assign ch_sel = 1'b0;
    end
  endgenerate

  // Channel decode and prescaler tick for each channel
  always_comb begin
    hit  = '0;
    tick = '0;
    for (int c = 0; c < NCH; c++) begin
      hit[c]  = (ch_sel == CW'(c));
      tick[c] = en_q[c] && (psc_cnt_q[c] == psc_q[c]);
    end
  end

  // Next state: read-clear, then terminal/count update, then CPU write (last assignment wins)
  always_comb begin
    en_d  = en_q;
    tmr_d = tmr_q;
    tog_d = tog_q;
    os_d  = os_q;
    ie_d  = ie_q;
    for (int c = 0; c < NCH; c++) begin
      timer_d[c]   = timer_q[c];
      period_d[c]  = period_q[c];
      psc_d[c]     = psc_q[c];
      psc_cnt_d[c] = psc_cnt_q[c];

      if (en_q[c]) begin
        psc_cnt_d[c] = tick[c] ? '0 : psc_cnt_q[c] + 1'b1;
      end

      // Lowest priority: a CONTROL read acknowledges the pending event
      if (rden && hit[c] && (reg_sel == REG_CTRL)) begin
        tmr_d[c] = 1'b0;
      end

      // A terminal event overrides the read-clear so it is never lost
      if (tick[c]) begin
        if (timer_q[c] == period_q[c]) begin
          timer_d[c] = '0;
          tmr_d[c]   = 1'b1;
          tog_d[c]   = ~tog_q[c];
          if (os_q[c]) begin
            en_d[c] = 1'b0;
          end
        end else begin
          timer_d[c] = timer_q[c] + 1'b1;
        end
      end

      // Highest priority: the CPU write to the addressed register
      if (wren && hit[c]) begin
        unique case (reg_sel)
          REG_TIMER: begin
            timer_d[c]   = din;
            psc_cnt_d[c] = '0;
          end
          REG_PERIOD: begin
            period_d[c] = din;
          end
          REG_CTRL: begin
            en_d[c]  = din[0];
            tmr_d[c] = din[1];
            tog_d[c] = din[2];
            os_d[c]  = din[3];
            ie_d[c]  = din[4];
          end
          REG_PSC: begin
            psc_d[c]     = din[PSC_WIDTH-1:0];
            psc_cnt_d[c] = '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State registers with asynchronous reset to the parameterised defaults
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        timer_q[c]   <= '0;
        period_q[c]  <= PERIOD_RST;
        psc_q[c]     <= '0;
        psc_cnt_q[c] <= '0;
      end
      en_q  <= {NCH{ENBIT}};
      tmr_q <= '0;
      tog_q <= '0;
      os_q  <= '0;
      ie_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        timer_q[c]   <= timer_d[c];
        period_q[c]  <= period_d[c];
        psc_q[c]     <= psc_d[c];
        psc_cnt_q[c] <= psc_cnt_d[c];
      end
      en_q  <= en_d;
      tmr_q <= tmr_d;
      tog_q <= tog_d;
      os_q  <= os_d;
      ie_q  <= ie_d;
      irq_q <= |(tmr_q & ie_q);
    end
  end

  // Read mux for the addressed channel; unused bits stay zero
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_TIMER:  rdata = timer_q[ch_sel];
      REG_PERIOD: rdata = period_q[ch_sel];
      REG_CTRL:   rdata[4:0] = {ie_q[ch_sel], os_q[ch_sel], tog_q[ch_sel], tmr_q[ch_sel], en_q[ch_sel]};
      REG_PSC:    rdata[PSC_WIDTH-1:0] = psc_q[ch_sel];
      default:    rdata = '0;
    endcase
  end

  assign dout = rden ? rdata : '0;
  assign irq  = irq_q;
  assign tog  = tog_q;

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: directed register-map scenarios plus random bus traffic,
// checked against a per-channel register model through an expectation queue.
module tb_timer_multi;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int unsigned MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         wren = 1'b0;
  logic         rden = 1'b0;
  logic [3:0]   addr = '0;
  logic         irq;
  logic [N-1:0] tog;

  always #5 clk = ~clk;

  timer_multi #(
    .WIDTH(W), .NCH(N), .PSC_WIDTH(PW), .PERIOD(32'h0000000F), .ENBIT(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout), .wren(wren),
    .rden(rden), .addr(addr), .irq(irq), .tog(tog)
  );

  // Reference model: one record of architectural registers per channel
  typedef struct {
    int unsigned timer;
    int unsigned period;
    int unsigned psc;
    int unsigned pscnt;
    bit en, tmr, tg, os, ie;
  } ch_t;

  typedef struct {
    logic [W-1:0] dout;
    logic         irq;
    logic [N-1:0] tog;
  } exp_t;

  ch_t  m [N];
  bit   irq_m;
  exp_t sbq [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m[i].timer  = 0;
      m[i].period = 32'h0F;
      m[i].psc    = 0;
      m[i].pscnt  = 0;
      m[i].en     = 1'b0;
      m[i].tmr    = 1'b0;
      m[i].tg     = 1'b0;
      m[i].os     = 1'b0;
      m[i].ie     = 1'b0;
    end
    irq_m = 1'b0;
  endtask

  function automatic logic [W-1:0] model_read(input logic [3:0] a);
    ch_t c;
    c = m[a[3:2]];
    case (a[1:0])
      2'd0:    return W'(c.timer);
      2'd1:    return W'(c.period);
      2'd2:    return W'({c.ie, c.os, c.tg, c.tmr, c.en});
      default: return W'(c.psc);
    endcase
  endfunction

  function automatic logic [N-1:0] model_tog();
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) t[i] = m[i].tg;
    return t;
  endfunction

  // One clock edge of architectural behaviour, applying effects in rising priority order
  task automatic model_step(input bit we, input bit re, input logic [3:0] a, input logic [W-1:0] d);
    ch_t nxt [N];
    bit  ir;
    ir = 1'b0;
    for (int i = 0; i < N; i++) ir |= (m[i].tmr & m[i].ie);
    for (int i = 0; i < N; i++) begin
      ch_t s;
      bit  tick;
      bit  sel;
      s    = m[i];
      sel  = (int'(a[3:2]) == i);
      tick = m[i].en && (m[i].pscnt == m[i].psc);
      if (m[i].en) s.pscnt = tick ? 0 : m[i].pscnt + 1;
      if (re && sel && a[1:0] == 2'd2) s.tmr = 1'b0;
      if (tick) begin
        if (m[i].timer == m[i].period) begin
          s.timer = 0;
          s.tmr   = 1'b1;
          s.tg    = !m[i].tg;
          if (m[i].os) s.en = 1'b0;
        end else begin
          s.timer = (m[i].timer + 1) & MASK;
        end
      end
      if (we && sel) begin
        case (a[1:0])
          2'd0: begin s.timer = d; s.pscnt = 0; end
          2'd1: s.period = d;
          2'd2: {s.ie, s.os, s.tg, s.tmr, s.en} = d[4:0];
          default: begin s.psc = d; s.pscnt = 0; end
        endcase
      end
      nxt[i] = s;
    end
    m     = nxt;
    irq_m = ir;
  endtask

  // One bus cycle: drive, queue the expected outputs, optionally check a literal, advance the model
  task automatic cyc(input bit we, input bit re, input logic [3:0] a, input logic [W-1:0] d,
                     input bit chk = 1'b0, input logic [W-1:0] lit = '0, input string nm = "");
    exp_t e;
    @(negedge clk);
    wren = we;
    rden = re;
    addr = a;
    din  = d;
    e.dout = re ? model_read(a) : '0;
    e.irq  = irq_m;
    e.tog  = model_tog();
    sbq.push_back(e);
    if (chk) begin
      #1;
      check(nm, dout, lit);
    end
    @(posedge clk);
    model_step(we, re, a, d);
  endtask

  // Monitor: compares DUT outputs against the queued expectations each cycle
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_dout", dout, e.dout);
        check("sb_irq", irq, e.irq);
        check("sb_tog", tog, e.tog);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ra;
    logic [W-1:0] rd;
    int op;

    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    cyc(0, 1, 4'h1, 0, 1, 8'h0F, "rst_period");
    cyc(0, 1, 4'h0, 0, 1, 8'h00, "rst_timer");
    cyc(0, 1, 4'h2, 0, 1, 8'h00, "rst_ctrl");
    for (int a = 0; a < 16; a++) cyc(0, 0, 4'(a), 0, 1, 8'h00, "rden0_zero");

    // ch1: period 3, no prescale -> 0,1,2,3,0 then TMR and TOGGLE set
    cyc(1, 0, 4'h5, 8'd3);
    cyc(1, 0, 4'h7, 8'd0);
    cyc(1, 0, 4'h6, 8'h01);
    cyc(0, 1, 4'h4, 0, 1, 8'd0, "ch1_t0");
    cyc(0, 1, 4'h4, 0, 1, 8'd1, "ch1_t1");
    cyc(0, 1, 4'h4, 0, 1, 8'd2, "ch1_t2");
    cyc(0, 1, 4'h4, 0, 1, 8'd3, "ch1_t3");
    cyc(0, 1, 4'h4, 0, 1, 8'd0, "ch1_wrap");
    cyc(0, 1, 4'h6, 0, 1, 8'h07, "ch1_ctrl_event");
    repeat (8) cyc(0, 1, 4'h4, 0);
    cyc(1, 0, 4'h6, 8'h00);

    // ch2: prescale 2, period 1, one-shot with IE -> event 6 cycles after enable
    cyc(1, 0, 4'hB, 8'd2);
    cyc(1, 0, 4'h9, 8'd1);
    cyc(1, 0, 4'hA, 8'h19);
    repeat (6) cyc(0, 0, 4'h0, 0);
    cyc(0, 1, 4'hA, 0, 1, 8'h1E, "ch2_oneshot_ctrl");
    repeat (4) cyc(0, 0, 4'h0, 0);
    cyc(0, 1, 4'h8, 0, 1, 8'h00, "ch2_timer_held");

    // ch0: CONTROL read on the terminal-event cycle keeps TMR
    cyc(1, 0, 4'h1, 8'd2);
    cyc(1, 0, 4'h3, 8'd0);
    cyc(1, 0, 4'h2, 8'h11);
    cyc(0, 0, 4'h0, 0);
    cyc(0, 0, 4'h0, 0);
    cyc(0, 1, 4'h2, 0, 1, 8'h11, "ch0_ctrl_on_event");
    cyc(0, 1, 4'h2, 0, 1, 8'h17, "ch0_ctrl_tmr_kept");
    repeat (3) cyc(0, 0, 4'h0, 0);
    cyc(1, 0, 4'h2, 8'h00);

    // ch3: period lowered below the count -> runs through the wrap before the event
    cyc(1, 0, 4'hD, 8'd5);
    cyc(1, 0, 4'hF, 8'd0);
    cyc(1, 0, 4'hE, 8'h01);
    repeat (4) cyc(0, 0, 4'h0, 0);
    cyc(1, 0, 4'hD, 8'd2);
    for (int k = 0; k < 255; k++)
      cyc(0, 1, 4'hC, 0, (k == 0 || k == 251 || k == 254), (k == 0) ? 8'd5 : 8'd0, "ch3_wrap");
    cyc(0, 1, 4'hE, 0, 1, 8'h07, "ch3_event_ctrl");
    cyc(1, 0, 4'hC, 8'h10);
    cyc(0, 1, 4'hC, 0, 1, 8'h10, "ch3_timer_write_on_tick");
    cyc(1, 0, 4'hE, 8'h00);

    // Random bus traffic
    for (int n = 0; n < 3000; n++) begin
      op = int'($urandom_range(0, 3));
      ra = 4'($urandom_range(0, 15));
      if (ra[1:0] == 2'd1 || ra[1:0] == 2'd3) rd = W'($urandom_range(0, 6));
      else rd = W'($urandom_range(0, 255));
      cyc(op == 1 || op == 3, op == 2 || op == 3, ra, rd);
    end

    // Asynchronous reset while ch1 is counting with TOGGLE set
    cyc(1, 0, 4'h5, 8'h20);
    cyc(1, 0, 4'h7, 8'd0);
    cyc(1, 0, 4'h6, 8'h05);
    repeat (5) cyc(0, 0, 4'h0, 0);
    @(negedge clk);
    wren  = 1'b0;
    rden  = 1'b1;
    addr  = 4'h4;
    reset = 1'b1;
    #1;
    check("arst_tog", tog, 4'b0000);
    check("arst_irq", irq, 1'b0);
    check("arst_timer", dout, 8'h00);
    addr = 4'h5;
    #1;
    check("arst_period", dout, 8'h0F);
    addr = 4'h6;
    #1;
    check("arst_ctrl", dout, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    rden  = 1'b0;
    repeat (4) cyc(0, 1, 4'h4, 0, 1, 8'h00, "post_rst_timer_held");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
